// File: rtl/stackseq_pkg.sv
// Shared definitions for the stack push/pull sequencer: FSM states,
// the fixed stack page and the operation encodings.
package stackseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_WR,
    ST_PULL_INC,
    ST_PULL_RD,
    ST_DONE
  } state_t;

  localparam logic [7:0] STACK_PAGE = 8'h01;

  localparam logic PUSH = 1'b0;
  localparam logic PULL = 1'b1;

endpackage

// File: rtl/stackseq.sv
// Stack push/pull sequencer: steps the stack pointer and issues page-1
// memory accesses for a 1..3 byte transfer, then pulses done.
module stackseq
  import stackseq_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       req,
  input  logic       pull,
  input  logic [1:0] nbytes,
  input  logic [7:0] sp,
  output logic       busy,
  output logic       done,
  output logic       sp_adloa,
  output logic       sp_dec,
  output logic       sp_inc,
  output logic [7:0] abh,
  output logic [7:0] abl,
  output logic       mem_we,
  output logic       mem_re,
  output logic [1:0] byte_idx,
  output logic       wrap
);

  state_t     state_reg, state_next;
  logic [1:0] remain_reg, remain_next;
  logic [1:0] idx_reg, idx_next;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg  <= ST_IDLE;
      remain_reg <= 2'd0;
      idx_reg    <= 2'd0;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
      idx_reg    <= idx_next;
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign byte_idx = idx_reg;

  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    idx_next    = idx_reg;
    done        = 1'b0;
    sp_adloa    = 1'b0;
    sp_dec      = 1'b0;
    sp_inc      = 1'b0;
    abh         = 8'h00;
    abl         = 8'h00;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    wrap        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        remain_next = nbytes;
        idx_next    = 2'd0;
        if (req && (nbytes != 2'd0))
          state_next = (pull == PULL) ? ST_PULL_INC : ST_PUSH_WR;
      end

      ST_PUSH_WR: begin
        sp_adloa = 1'b1;
        abh      = STACK_PAGE;
        abl      = sp;
        mem_we   = 1'b1;
        sp_dec   = 1'b1;
        wrap     = (sp == 8'h00);
        if (remain_reg > 2'd1) begin
          remain_next = remain_reg - 2'd1;
          idx_next    = idx_reg + 2'd1;
        end else begin
          state_next = ST_DONE;
        end
      end

      // Pre-increment: the read in the following cycle uses the bumped pointer
      ST_PULL_INC: begin
        sp_inc     = 1'b1;
        wrap       = (sp == 8'hFF);
        state_next = ST_PULL_RD;
      end

      ST_PULL_RD: begin
        sp_adloa = 1'b1;
        abh      = STACK_PAGE;
        abl      = sp;
        mem_re   = 1'b1;
        if (remain_reg > 2'd1) begin
          remain_next = remain_reg - 2'd1;
          idx_next    = idx_reg + 2'd1;
          state_next  = ST_PULL_INC;
        end else begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        idx_next   = 2'd0;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stackseq.sv
// Randomized self-checking bench for stackseq: a stack pointer model drives
// sp, and each transfer is checked cycle by cycle against an expected trace.
module tb_stackseq;
  import stackseq_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       req = 1'b0;
  logic       pull = 1'b0;
  logic [1:0] nbytes = 2'd0;
  logic [7:0] sp_val = 8'h00;
  logic       sp_load = 1'b0;
  logic [7:0] sp_load_val = 8'h00;

  logic       busy, done, sp_adloa, sp_dec, sp_inc, mem_we, mem_re, wrap;
  logic [7:0] abh, abl;
  logic [1:0] byte_idx;

  int n_tests = 0;
  int n_fail  = 0;

  stackseq dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .pull     (pull),
    .nbytes   (nbytes),
    .sp       (sp_val),
    .busy     (busy),
    .done     (done),
    .sp_adloa (sp_adloa),
    .sp_dec   (sp_dec),
    .sp_inc   (sp_inc),
    .abh      (abh),
    .abl      (abl),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .byte_idx (byte_idx),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Stack pointer register responding to the DUT strobes
  always @(posedge clk) begin
    if (sp_load)     sp_val <= sp_load_val;
    else if (sp_dec) sp_val <= sp_val - 8'd1;
    else if (sp_inc) sp_val <= sp_val + 8'd1;
  end

  function automatic logic [25:0] pk(input logic b, input logic d, input logic a,
                                     input logic dc, input logic ic,
                                     input logic [7:0] h, input logic [7:0] l,
                                     input logic we, input logic re,
                                     input logic [1:0] ix, input logic w);
    return {b, d, a, dc, ic, h, l, we, re, ix, w};
  endfunction

  function automatic logic [25:0] obs();
    return pk(busy, done, sp_adloa, sp_dec, sp_inc, abh, abl,
              mem_we, mem_re, byte_idx, wrap);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called around a falling edge while the DUT is idle
  task automatic set_sp(input logic [7:0] v);
    sp_load     = 1'b1;
    sp_load_val = v;
    @(posedge clk);
    #1 sp_load = 1'b0;
    @(negedge clk);
  endtask

  // Issue one transfer and compare every cycle through the following IDLE cycle
  task automatic run_op(input logic op, input logic [1:0] n, input bit hold);
    logic [25:0] exp_q[$];
    logic [25:0] o;
    logic [7:0]  s, a;
    s = sp_val;
    for (int k = 0; k < int'(n); k++) begin
      if (op == PUSH) begin
        a = s - 8'(k);
        exp_q.push_back(pk(1, 0, 1, 1, 0, 8'h01, a, 1, 0, 2'(k), a == 8'h00));
      end else begin
        a = s + 8'(k);
        exp_q.push_back(pk(1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 2'(k), a == 8'hFF));
        exp_q.push_back(pk(1, 0, 1, 0, 0, 8'h01, a + 8'd1, 0, 1, 2'(k), 0));
      end
    end
    exp_q.push_back(pk(1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0));
    exp_q.push_back(26'd0);
    req    = 1'b1;
    pull   = op;
    nbytes = n;
    @(posedge clk);
    #1 if (!hold) req = 1'b0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      o = obs();
      if (i == exp_q.size() - 2) o[2:1] = 2'b00;
      check_eq($sformatf("%s%0d_sp%h_c%0d", op ? "pull" : "push", n, s, i + 1),
               32'(o), 32'(exp_q[i]));
    end
    $display("[TB] %s n=%0d sp=%h hold=%0d cycles=%0d", op ? "pull" : "push",
             n, s, hold, exp_q.size());
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 32'(obs()), 32'd0);
    clr = 1'b1;

    set_sp(8'hFA);
    run_op(PUSH, 2'd1, 1'b0);
    set_sp(8'hFA);
    run_op(PUSH, 2'd3, 1'b0);
    set_sp(8'hF7);
    run_op(PULL, 2'd2, 1'b0);
    set_sp(8'h00);
    run_op(PUSH, 2'd2, 1'b0);
    set_sp(8'hFF);
    run_op(PULL, 2'd1, 1'b0);

    // Zero byte count is ignored
    req = 1'b1; pull = PUSH; nbytes = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("zero_nbytes", {30'd0, busy, done}, 32'd0);
    end
    req = 1'b0;
    $display("[TB] zero-count request held 3 cycles");

    // Held request: accepted once, then again only after the IDLE cycle
    set_sp(8'h40);
    run_op(PUSH, 2'd2, 1'b1);
    run_op(PUSH, 2'd2, 1'b0);

    // Asynchronous reset during the second read of a pull 2
    set_sp(8'hF7);
    req = 1'b1; pull = PULL; nbytes = 2'd2;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_pre_rd2", 32'(obs()), 32'(pk(1, 0, 1, 0, 0, 8'h01, 8'hF9, 0, 1, 2'd1, 0)));
    #2 clr = 1'b0;
    #1 check_eq("rst_async", 32'(obs()), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_hold", 32'(obs()), 32'd0);
    end
    clr = 1'b1;
    $display("[TB] reset during pull, released");
    run_op(PUSH, 2'd1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(3) == 0) set_sp(8'($urandom));
      if ($urandom_range(4) == 0) begin
        req = 1'b1; nbytes = 2'd0; pull = 1'($urandom);
        @(negedge clk);
        check_eq("rand_zero", {30'd0, busy, done}, 32'd0);
        req = 1'b0;
      end
      run_op(1'($urandom_range(1)), 2'($urandom_range(3, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
